// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file address width, link-register address and address type.
package rf_pkg;
    localparam int RF_ADDR_WIDTH = 4;
    localparam logic [RF_ADDR_WIDTH-1:0] RF_LINK_ADDR = 4'hD;
    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
endpackage

// File: rtl/rf_write_addr_mux.sv
// rf_write_addr_mux: selects the register-file write address and keeps a write-back copy.
// Ports:
//   CLK                 system clock, registered outputs update on rising edge
//   Reset               asynchronous active-low reset of all registered state
//   RFWA                write-address select: 0 = instruction field, 1 = LINK_ADDR
//   InstructionRegister destination-register field of the current instruction
//   WriteEnable         register-file write request for the current instruction
//   Output              combinational selected write address
//   OutputReg           registered write address for the write-back stage
//   WriteEnableReg      registered WriteEnable, aligned with OutputReg
//   LinkSelReg          registered RFWA, marks OutputReg as a link write
module rf_write_addr_mux
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] LINK_ADDR = RF_LINK_ADDR
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  RFWA,
    input  logic [ADDR_WIDTH-1:0] InstructionRegister,
    input  logic                  WriteEnable,
    output logic [ADDR_WIDTH-1:0] Output,
    output logic [ADDR_WIDTH-1:0] OutputReg,
    output logic                  WriteEnableReg,
    output logic                  LinkSelReg
);
    logic [ADDR_WIDTH-1:0] output_reg_d, output_reg_q;
    logic                  we_reg_d, we_reg_q;
    logic                  link_sel_d, link_sel_q;
    // Case with an X default so an unknown select yields a fully unknown address.
    always_comb begin
        Output = 'x;
        case (RFWA)
            1'b0: Output = InstructionRegister;
            1'b1: Output = LINK_ADDR;
            default: Output = 'x;
        endcase
    end
    // Address and link flag are only captured for real writes; the enable always follows.
    always_comb begin
        we_reg_d     = WriteEnable;
        output_reg_d = WriteEnable ? Output : output_reg_q;
        link_sel_d   = WriteEnable ? RFWA : link_sel_q;
    end
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            output_reg_q <= '0;
            we_reg_q     <= 1'b0;
            link_sel_q   <= 1'b0;
        end else begin
            output_reg_q <= output_reg_d;
            we_reg_q     <= we_reg_d;
            link_sel_q   <= link_sel_d;
        end
    end
    assign OutputReg      = output_reg_q;
    assign WriteEnableReg = we_reg_q;
    assign LinkSelReg     = link_sel_q;
endmodule

// File: tb/tb_rf_write_addr_mux.sv
// tb_rf_write_addr_mux: randomized self-checking bench with a behavioural reference model.
module tb_rf_write_addr_mux;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rfwa = 1'b0;
    logic [3:0] ir = 4'h0;
    logic       we = 1'b0;
    logic [3:0] out, out_reg;
    logic       we_reg, link_reg;
    int         total = 0;
    int         passed = 0;
    logic [3:0] m_addr = 4'h0;
    logic       m_we = 1'b0;
    logic       m_link = 1'b0;
    rf_write_addr_mux dut (
        .CLK(clk), .Reset(reset), .RFWA(rfwa), .InstructionRegister(ir),
        .WriteEnable(we), .Output(out), .OutputReg(out_reg),
        .WriteEnableReg(we_reg), .LinkSelReg(link_reg)
    );
    always #5 clk = ~clk;
    function automatic logic [3:0] sel(input logic s, input logic [3:0] f);
        return s ? 4'hD : f;
    endfunction
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        else passed++;
    endtask
    task automatic check_regs(input string tag);
        check({tag, "_oreg"}, {4'h0, out_reg}, {4'h0, m_addr});
        check({tag, "_we"}, {7'h0, we_reg}, {7'h0, m_we});
        check({tag, "_link"}, {7'h0, link_reg}, {7'h0, m_link});
    endtask
    task automatic cycle(input logic s, input logic [3:0] f, input logic w, input string tag);
        @(negedge clk);
        rfwa = s; ir = f; we = w;
        #1 check({tag, "_out"}, {4'h0, out}, {4'h0, sel(s, f)});
        @(posedge clk);
        #1;
        m_we = w;
        if (w) begin
            m_addr = sel(s, f);
            m_link = s;
        end
        check_regs(tag);
    endtask
    initial begin
        #100;
        check("rst_out", {4'h0, out}, 8'h00);
        check_regs("rst");
        rfwa = 1'b1;
        #10 check("rst_link_out", {4'h0, out}, 8'h0D);
        for (int i = 0; i < 16; i++) begin
            rfwa = 1'b0; ir = 4'(i);
            #1 check("sweep_ir", {4'h0, out}, {4'h0, 4'(i)});
            rfwa = 1'b1;
            #1 check("sweep_link", {4'h0, out}, 8'h0D);
        end
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 4'h7, 1'b1, "cap7");
        cycle(1'b1, 4'h7, 1'b1, "capD");
        cycle(1'b0, 4'h3, 1'b0, "hold");
        reset = 1'b0;
        m_addr = 4'h0; m_we = 1'b0; m_link = 1'b0;
        #1 check_regs("async_rst");
        ir = 4'hA; rfwa = 1'b0;
        #1 check("rst_track", {4'h0, out}, 8'h0A);
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 4'hD, 1'b1, "ir_d");
        for (int n = 0; n < 300; n++) begin
            cycle(1'($urandom), 4'($urandom), 1'($urandom), "rand");
            if ($urandom_range(7) == 0) begin
                reset = 1'b0;
                m_addr = 4'h0; m_we = 1'b0; m_link = 1'b0;
                #1 check_regs("rand_rst");
                reset = 1'b1;
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rf_write_addr_mux.md
Name: rf_write_addr_mux

Overview:
Selects the register-file write address for the datapath. The address comes either from the instruction's destination field or from the fixed link register, 4'hD, used by call/link instructions. The combinational result drives the register file's write-address port directly. A registered copy, qualified by write-enable, feeds the write-back pipeline stage. Sits between the instruction register and the register file.

Parameters:
ADDR_WIDTH, 4, width of register-file addresses and of the InstructionRegister field.
LINK_ADDR, 4'hD, fixed address selected when RFWA=1.

Ports:
CLK  input  1  system clock; registered outputs update on rising edge.
Reset  input  1  asynchronous, active-low reset; 0 clears all registered state immediately.
RFWA  input  1  write-address select: 0 = instruction field, 1 = LINK_ADDR.
InstructionRegister  input  ADDR_WIDTH  destination-register field of the current instruction.
WriteEnable  input  1  register-file write request for the current instruction.
Output  output  ADDR_WIDTH  combinational selected write address.
OutputReg  output  ADDR_WIDTH  registered write address for the write-back stage.
WriteEnableReg  output  1  registered WriteEnable, aligned with OutputReg.
LinkSelReg  output  1  registered RFWA; flags that OutputReg is a link write.

Behaviour:
- Output = RFWA ? LINK_ADDR : InstructionRegister.
- Output is purely combinational, with zero latency. It does not depend on CLK or Reset; it stays valid even while Reset=0.
- Output settles within the same simulation delta after any input change. No clock edge is needed.
- When RFWA is X/Z, Output is X.
- Registered stage, on rising CLK with Reset=1:
  - WriteEnableReg <= WriteEnable.
  - If WriteEnable=1: OutputReg <= Output and LinkSelReg <= RFWA.
  - If WriteEnable=0: OutputReg and LinkSelReg hold their values.
- Latency: 1 cycle from input to OutputReg/WriteEnableReg.
- Reset=0 (asynchronous, any time, including mid-operation):
  - OutputReg=0, WriteEnableReg=0, LinkSelReg=0 immediately.
  - These hold until the first rising CLK after Reset returns to 1.
- Reset deasserting coincident with a CLK edge: that edge is ignored; capture starts on the next edge.
- InstructionRegister=4'hD with RFWA=0 gives the same address as a link write. LinkSelReg distinguishes the two cases.
- All ADDR_WIDTH values are legal; no range checks and no wrap-around behaviour.

Decomposition:
- Shared package rf_pkg holds:
  - RF_ADDR_WIDTH = 4
  - RF_LINK_ADDR = 4'hD
  - typedef rf_addr_t, logic [RF_ADDR_WIDTH-1:0]
- The select logic and the pipeline register live in one module; no sub-module is needed.
- Optional: factor the capture register into rf_addr_pipe_reg if other stages reuse it.

Test Plan:
1. Reset=0, RFWA=0, InstructionRegister=0, wait 100 ns -> Output=4'h0; OutputReg=0, WriteEnableReg=0, LinkSelReg=0.
2. Set RFWA=1, wait 10 ns with no clock edge -> Output=4'hD.
3. RFWA=0, sweep InstructionRegister 0..F -> Output equals InstructionRegister every step. RFWA=1 for each value -> Output=4'hD.
4. Reset=1, WriteEnable=1, RFWA=0, InstructionRegister=4'h7, one rising edge -> OutputReg=7, WriteEnableReg=1, LinkSelReg=0. Next edge with RFWA=1 -> OutputReg=D, LinkSelReg=1.
5. WriteEnable=0, InstructionRegister=4'h3, clock edge -> OutputReg holds D, WriteEnableReg=0, LinkSelReg stays 1.
6. With OutputReg=D, assert Reset=0 between edges -> OutputReg=0 immediately, with no clock needed. Output still tracks inputs.
